// File: rtl/game_ctrl_if.sv
// Signal bundle between the game controller and its surrounding datapath.
// The slave side is the controller; the master side drives buttons, ticks and scoring.
interface game_ctrl_if;
    logic       mode;
    logic       select;
    logic       tick;
    logic       score_ack;
    logic [2:0] exact;
    logic       code_load;
    logic       guess_en;
    logic       hist_wr;
    logic       score_req;
    logic [2:0] turn;
    logic       win;
    logic       lose;
    logic [2:0] state;

    modport master (
        output mode, select, tick, score_ack, exact,
        input  code_load, guess_en, hist_wr, score_req, turn, win, lose, state
    );

    modport slave (
        input  mode, select, tick, score_ack, exact,
        output code_load, guess_en, hist_wr, score_req, turn, win, lose, state
    );
endinterface

// File: rtl/game_ctrl.sv
// Game sequencing FSM: loads a secret, collects guesses, requests scoring,
// and holds a WIN/LOSE result for a number of ticks before returning to idle.
module game_ctrl #(
    parameter int unsigned MAX_TURNS = 8,
    parameter int unsigned END_TICKS = 5
) (
    input  logic        clk,
    input  logic        reset,
    game_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StEntry  = 3'd2,
        StSubmit = 3'd3,
        StScore  = 3'd4,
        StWin    = 3'd5,
        StLose   = 3'd6
    } state_e;

    localparam logic [2:0] LastTurn = 3'(MAX_TURNS - 1);
    localparam logic [3:0] EndCount = 4'(END_TICKS);

    state_e     state_q;
    logic [2:0] turn_q;
    logic [3:0] end_cnt_q;
    logic       code_load_q;
    logic       hist_wr_q;
    logic       score_req_q;
    logic       win_q;
    logic       lose_q;

    logic       hit;
    logic [3:0] end_cnt_inc;

    // Exact counts 5..7 are out of range and count as a full match.
    assign hit         = (bus.exact >= 3'd4);
    assign end_cnt_inc = end_cnt_q + 4'd1;

    // State, turn, end counter and registered outputs, all set for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            turn_q      <= 3'd0;
            end_cnt_q   <= 4'd0;
            code_load_q <= 1'b0;
            hist_wr_q   <= 1'b0;
            score_req_q <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            code_load_q <= 1'b0;
            hist_wr_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    turn_q    <= 3'd0;
                    end_cnt_q <= 4'd0;
                    if (bus.select) begin
                        state_q     <= StLoad;
                        code_load_q <= 1'b1;
                    end
                end
                StLoad: begin
                    turn_q  <= 3'd0;
                    state_q <= StEntry;
                end
                StEntry: begin
                    if (bus.select && !bus.mode) begin
                        state_q   <= StSubmit;
                        hist_wr_q <= 1'b1;
                    end
                end
                StSubmit: begin
                    state_q     <= StScore;
                    score_req_q <= 1'b1;
                end
                StScore: begin
                    if (bus.score_ack) begin
                        score_req_q <= 1'b0;
                        end_cnt_q   <= 4'd0;
                        if (hit) begin
                            state_q <= StWin;
                            win_q   <= 1'b1;
                        end else if (turn_q == LastTurn) begin
                            state_q <= StLose;
                            lose_q  <= 1'b1;
                        end else begin
                            turn_q  <= turn_q + 3'd1;
                            state_q <= StEntry;
                        end
                    end
                end
                StWin, StLose: begin
                    // Select wins over a simultaneous tick; either way the counter is cleared.
                    if (bus.select || (bus.tick && end_cnt_inc == EndCount)) begin
                        state_q   <= StIdle;
                        turn_q    <= 3'd0;
                        end_cnt_q <= 4'd0;
                        win_q     <= 1'b0;
                        lose_q    <= 1'b0;
                    end else if (bus.tick) begin
                        end_cnt_q <= end_cnt_inc;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    turn_q      <= 3'd0;
                    end_cnt_q   <= 4'd0;
                    score_req_q <= 1'b0;
                    win_q       <= 1'b0;
                    lose_q      <= 1'b0;
                end
            endcase
        end
    end

    // Guess entry follows mode live while in ENTRY; everything else is registered.
    assign bus.guess_en  = (state_q == StEntry) && !bus.mode;
    assign bus.code_load = code_load_q;
    assign bus.hist_wr   = hist_wr_q;
    assign bus.score_req = score_req_q;
    assign bus.turn      = turn_q;
    assign bus.win       = win_q;
    assign bus.lose      = lose_q;
    assign bus.state     = state_q;

endmodule
